// File: rtl/move_list_store.sv
// Indexed move-list buffer: the generator fills it, list_done seals it, the reader fetches
// entries by index with one-cycle latency, and am_clear_moves discards the list.
module move_list_store #(
    parameter int MAX_POSITIONS_LOG2 = 8,
    parameter int EVAL_WIDTH         = 24,
    parameter int UCI_WIDTH          = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          move_valid_in,
    input  logic [UCI_WIDTH-1:0]          move_uci_in,
    input  logic [EVAL_WIDTH-1:0]         move_eval_in,
    input  logic                          move_capture_in,
    input  logic                          move_white_in_check_in,
    input  logic                          move_black_in_check_in,
    input  logic                          list_done_in,
    input  logic [MAX_POSITIONS_LOG2-1:0] am_move_index,
    input  logic                          am_clear_moves,
    output logic                          am_idle,
    output logic                          am_moves_ready,
    output logic                          am_move_ready,
    output logic [MAX_POSITIONS_LOG2-1:0] am_move_count,
    output logic [UCI_WIDTH-1:0]          uci_out,
    output logic [EVAL_WIDTH-1:0]         eval_out,
    output logic                          capture_out,
    output logic                          white_in_check_out,
    output logic                          black_in_check_out,
    output logic                          overflow_out
);

    localparam int ENTRY_W = UCI_WIDTH + EVAL_WIDTH + 3;
    localparam int DEPTH   = 1 << MAX_POSITIONS_LOG2;

    localparam logic [1:0] FILL  = 2'd0;
    localparam logic [1:0] READY = 2'd1;
    localparam logic [1:0] CLEAR = 2'd2;

    logic [1:0]                    state;
    logic [MAX_POSITIONS_LOG2-1:0] count;
    logic                          overflow;
    logic [ENTRY_W-1:0]            mem [DEPTH];
    logic [ENTRY_W-1:0]            rd_q;
    logic                          rd_valid;
    logic                          full;
    logic                          wr_en;

    // The last slot is never used so that count itself can express "full".
    assign full  = (count == '1);
    assign wr_en = (state == FILL) && move_valid_in && !am_clear_moves && !full;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= FILL;
            count    <= '0;
            overflow <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= (state == READY) && !am_clear_moves && (am_move_index < count);
            case (state)
                FILL: begin
                    if (am_clear_moves) begin
                        state    <= CLEAR;
                        count    <= '0;
                        overflow <= 1'b0;
                    end else begin
                        if (wr_en)
                            count <= count + MAX_POSITIONS_LOG2'(1);
                        else if (move_valid_in)
                            overflow <= 1'b1;
                        if (list_done_in)
                            state <= READY;
                    end
                end
                READY: begin
                    if (am_clear_moves) begin
                        state    <= CLEAR;
                        count    <= '0;
                        overflow <= 1'b0;
                    end
                end
                CLEAR: begin
                    state    <= FILL;
                    count    <= '0;
                    overflow <= 1'b0;
                end
                default: state <= FILL;
            endcase
        end
    end

    // Plain synchronous-read RAM; its contents are never cleared, validity comes from count.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[count] <= {move_uci_in, move_eval_in, move_capture_in,
                           move_white_in_check_in, move_black_in_check_in};
        rd_q <= mem[am_move_index];
    end

    assign {uci_out, eval_out, capture_out, white_in_check_out, black_in_check_out} =
        rd_valid ? rd_q : '0;

    assign am_move_ready  = rd_valid;
    assign am_moves_ready = (state == READY);
    assign am_idle        = (state == FILL) && (count == '0);
    assign am_move_count  = count;
    assign overflow_out   = overflow;

endmodule

// File: tb/tb_move_list_store.sv
// Self-checking bench for move_list_store: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue-based list model.
module tb_move_list_store;

    localparam int N   = 3;
    localparam int CAP = (1 << N) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          move_valid_in = 1'b0;
    logic [15:0]   move_uci_in = '0;
    logic [23:0]   move_eval_in = '0;
    logic          move_capture_in = 1'b0;
    logic          move_white_in_check_in = 1'b0;
    logic          move_black_in_check_in = 1'b0;
    logic          list_done_in = 1'b0;
    logic [N-1:0]  am_move_index = '0;
    logic          am_clear_moves = 1'b0;
    logic          am_idle, am_moves_ready, am_move_ready, capture_out;
    logic          white_in_check_out, black_in_check_out, overflow_out;
    logic [N-1:0]  am_move_count;
    logic [15:0]   uci_out;
    logic [23:0]   eval_out;

    int n_cmp  = 0;
    int n_fail = 0;

    move_list_store #(.MAX_POSITIONS_LOG2(N), .EVAL_WIDTH(24), .UCI_WIDTH(16)) dut (
        .clk(clk), .reset(reset),
        .move_valid_in(move_valid_in), .move_uci_in(move_uci_in), .move_eval_in(move_eval_in),
        .move_capture_in(move_capture_in), .move_white_in_check_in(move_white_in_check_in),
        .move_black_in_check_in(move_black_in_check_in), .list_done_in(list_done_in),
        .am_move_index(am_move_index), .am_clear_moves(am_clear_moves),
        .am_idle(am_idle), .am_moves_ready(am_moves_ready), .am_move_ready(am_move_ready),
        .am_move_count(am_move_count), .uci_out(uci_out), .eval_out(eval_out),
        .capture_out(capture_out), .white_in_check_out(white_in_check_out),
        .black_in_check_out(black_in_check_out), .overflow_out(overflow_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the stored list is a queue; the flags describe where the list is in its life.
    logic [42:0] q[$];
    bit          sealed   = 0;
    bit          clearing = 0;
    bit          ovf      = 0;
    bit          exp_mr   = 0;
    logic [42:0] exp_d    = '0;

    always @(negedge reset) begin
        q.delete();
        sealed = 0; clearing = 0; ovf = 0; exp_mr = 0; exp_d = '0;
    end

    always @(posedge clk) begin
        if (reset) begin
            exp_mr = sealed && !clearing && !am_clear_moves && (int'(am_move_index) < q.size());
            exp_d  = exp_mr ? q[am_move_index] : '0;
            if (clearing) begin
                clearing = 0;
            end else if (am_clear_moves) begin
                q.delete();
                ovf = 0; sealed = 0; clearing = 1;
            end else if (!sealed) begin
                if (move_valid_in) begin
                    if (q.size() < CAP)
                        q.push_back({move_uci_in, move_eval_in, move_capture_in,
                                     move_white_in_check_in, move_black_in_check_in});
                    else
                        ovf = 1;
                end
                if (list_done_in) sealed = 1;
            end
            #1;
            if (reset) begin
                check("m_idle",   am_idle, !sealed && !clearing && q.size() == 0);
                check("m_ready",  am_moves_ready, sealed);
                check("m_count",  am_move_count, q.size());
                check("m_ovf",    overflow_out, ovf);
                check("m_mready", am_move_ready, exp_mr);
                check("m_data",   {uci_out, eval_out, capture_out, white_in_check_out,
                                   black_in_check_out}, exp_d);
            end
        end
    end

    task automatic cyc(input logic v, input logic [15:0] u, input logic [23:0] e,
                       input logic [2:0] fl, input logic done, input logic [N-1:0] idx,
                       input logic clr);
        @(negedge clk);
        move_valid_in = v; move_uci_in = u; move_eval_in = e;
        {move_capture_in, move_white_in_check_in, move_black_in_check_in} = fl;
        list_done_in = done; am_move_index = idx; am_clear_moves = clr;
        @(posedge clk);
        #2;
    endtask

    task automatic idle_cyc();
        cyc(1'b0, '0, '0, 3'b000, 1'b0, '0, 1'b0);
    endtask

    task automatic clear_list();
        cyc(1'b0, '0, '0, 3'b000, 1'b0, '0, 1'b1);
        idle_cyc();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_idle", am_idle, 1'b1);
        check("rst_count", am_move_count, 0);
        check("rst_ready", am_moves_ready, 1'b0);
        check("rst_mready", am_move_ready, 1'b0);
        check("rst_ovf", overflow_out, 1'b0);
        check("rst_uci", uci_out, 0);
        @(negedge clk);
        reset = 1'b1;

        // Fill three moves, seal, read back.
        cyc(1'b1, 16'h0C14, 24'd5, 3'b100, 1'b0, '0, 1'b0);
        cyc(1'b1, 16'h1C24, 24'hFFFFF9, 3'b010, 1'b0, '0, 1'b0);
        cyc(1'b1, 16'h0001, 24'd0, 3'b001, 1'b0, '0, 1'b0);
        cyc(1'b0, '0, '0, 3'b000, 1'b1, '0, 1'b0);
        check("fill_count", am_move_count, 3);
        check("fill_ready", am_moves_ready, 1'b1);
        cyc(1'b0, '0, '0, 3'b000, 1'b0, 3'd0, 1'b0);
        check("rd0_uci", uci_out, 16'h0C14);
        check("rd0_eval", eval_out, 24'd5);
        check("rd0_cap", capture_out, 1'b1);
        check("rd0_mready", am_move_ready, 1'b1);
        cyc(1'b0, '0, '0, 3'b000, 1'b0, 3'd1, 1'b0);
        check("rd1_uci", uci_out, 16'h1C24);
        check("rd1_eval", eval_out, 24'hFFFFF9);
        check("rd1_wchk", white_in_check_out, 1'b1);
        cyc(1'b0, '0, '0, 3'b000, 1'b0, 3'd2, 1'b0);
        check("rd2_uci", uci_out, 16'h0001);
        check("rd2_bchk", black_in_check_out, 1'b1);
        cyc(1'b0, '0, '0, 3'b000, 1'b0, 3'd3, 1'b0);
        check("rd3_mready", am_move_ready, 1'b0);
        check("rd3_uci", uci_out, 16'h0000);

        // Clear handshake; write during CLEAR ignored, then a write sealed in the same cycle.
        cyc(1'b0, '0, '0, 3'b000, 1'b0, '0, 1'b1);
        check("clr_ready", am_moves_ready, 1'b0);
        check("clr_count", am_move_count, 0);
        check("clr_idle", am_idle, 1'b0);
        cyc(1'b1, 16'hDEAD, 24'd9, 3'b000, 1'b0, '0, 1'b0);
        check("clr2_idle", am_idle, 1'b1);
        check("clr2_count", am_move_count, 0);
        cyc(1'b1, 16'h1234, 24'd77, 3'b000, 1'b1, '0, 1'b0);
        check("seal_count", am_move_count, 1);
        check("seal_ready", am_moves_ready, 1'b1);
        cyc(1'b0, '0, '0, 3'b000, 1'b0, 3'd0, 1'b0);
        check("seal_uci", uci_out, 16'h1234);
        check("seal_mready", am_move_ready, 1'b1);

        // Empty list.
        clear_list();
        cyc(1'b0, '0, '0, 3'b000, 1'b1, '0, 1'b0);
        check("empty_ready", am_moves_ready, 1'b1);
        check("empty_count", am_move_count, 0);
        cyc(1'b0, '0, '0, 3'b000, 1'b0, 3'd0, 1'b0);
        check("empty_mready", am_move_ready, 1'b0);

        // Overflow: nine writes into seven slots.
        clear_list();
        for (int i = 0; i < 9; i++)
            cyc(1'b1, 16'h0100 + 16'(i), 24'(i), 3'b000, 1'b0, '0, 1'b0);
        check("ovf_count", am_move_count, 7);
        check("ovf_flag", overflow_out, 1'b1);
        cyc(1'b0, '0, '0, 3'b000, 1'b1, '0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            cyc(1'b0, '0, '0, 3'b000, 1'b0, N'(i), 1'b0);
            check("ovf_rd_uci", uci_out, 16'h0100 + 16'(i));
        end

        // Asynchronous reset with four entries in FILL.
        clear_list();
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 16'h0200 + 16'(i), 24'(i), 3'b111, 1'b0, '0, 1'b0);
        check("ar_count4", am_move_count, 4);
        @(negedge clk);
        move_valid_in = 1'b0; list_done_in = 1'b0; am_clear_moves = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("ar_idle", am_idle, 1'b1);
        check("ar_count", am_move_count, 0);
        check("ar_ready", am_moves_ready, 1'b0);
        check("ar_mready", am_move_ready, 1'b0);
        check("ar_ovf", overflow_out, 1'b0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #2;
        check("ar_rel_idle", am_idle, 1'b1);

        // Random traffic checked by the model every cycle.
        for (int i = 0; i < 800; i++) begin
            cyc(1'(($urandom % 10) < 6), 16'($urandom), 24'($urandom), 3'($urandom),
                1'(($urandom % 14) == 0), N'($urandom), 1'(($urandom % 12) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
